// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths, constants, FSM encoding and the prefetch entry layout
// for the instruction fetch controller.
package inst_fetch_ctrl_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] INST_STRIDE      = 32'd16;
  localparam logic [INST_W-1:0]      ZERO_DOUBLE_WORD = '0;
  localparam logic                   CHIP_ENABLE      = 1'b1;
  localparam logic                   CHIP_DISABLE     = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DEBUG = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch queue of {pc, inst} entries; head reads as zero when empty.
module fetch_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t din_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;

  // Pointers carry one wrap bit to tell full from empty.
  logic [PW:0]  wr_q, rd_q;
  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + ONE;
      if (pop_i)  rd_q <= rd_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q[PW-1:0]] <= din_i;
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[PW-1:0]];
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: sequential ROM fetch into a prefetch queue,
// redirect on flush, and a one-cycle debug read port sharing the ROM.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   rom_ce,
  output logic [INST_ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0]      rom_inst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] flush_pc,
  output logic                   if_valid,
  output logic [INST_W-1:0]      if_inst,
  output logic [INST_ADDR_W-1:0] if_pc,
  input  logic                   dbg_req,
  input  logic [INST_ADDR_W-1:0] dbg_addr,
  output logic                   dbg_ack,
  output logic [INST_W-1:0]      dbg_data
);
  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic                   dbg_ack_q;
  logic [INST_W-1:0]      dbg_data_q;
  logic                   fetch, pop, full, empty;
  fetch_entry_t           head;

  assign pop = if_valid && !stall && !flush;

  // DEBUG always returns to FETCH, so grants can never be back-to-back.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rom_ce   = CHIP_DISABLE;
    rom_addr = '0;
    fetch    = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (!flush && (!full || pop)) begin
          fetch    = 1'b1;
          rom_ce   = CHIP_ENABLE;
          rom_addr = pc_q;
          pc_d     = pc_q + INST_STRIDE;
        end
        if (dbg_req && !flush) state_d = ST_DEBUG;
      end
      ST_DEBUG: begin
        rom_ce   = CHIP_ENABLE;
        rom_addr = dbg_addr;
        state_d  = ST_FETCH;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (flush) pc_d = flush_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= ZERO_DOUBLE_WORD;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dbg_ack_q <= (state_q == ST_DEBUG);
      if (state_q == ST_DEBUG) dbg_data_q <= rom_inst;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fetch),
    .pop_i   (pop),
    .clear_i (flush),
    .din_i   ('{pc: pc_q, inst: rom_inst}),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign if_valid = !empty;
  assign if_inst  = head.inst;
  assign if_pc    = head.pc;
  assign dbg_ack  = dbg_ack_q;
  assign dbg_data = dbg_data_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: fetch stream, stall, flush, debug and reset.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_inst;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_addr = '0;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // ROM word is a tag plus the low address bits, so every address is distinct.
  assign rom_inst = 32'hC0DE_0000 | {16'h0, rom_addr[15:0]};

  inst_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ce", 32'(rom_ce), 32'd0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_data", dbg_data, 32'h0);

    // c0 IDLE, then sequential fetch
    tick(); rst_n = 1'b1;
    @(negedge clk); chk("idle_ce", 32'(rom_ce), 32'd0);
    tick(); @(negedge clk);
    chk("seq_ce1", 32'(rom_ce), 32'd1);
    chk("seq_a0", rom_addr, 32'h00);
    chk("seq_v0", 32'(if_valid), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick(); @(negedge clk);
      chk("seq_addr", rom_addr, 32'(i * 16));
      chk("seq_ifpc", if_pc, 32'((i - 1) * 16));
      chk("seq_inst", if_inst, 32'hC0DE_0000 | 32'((i - 1) * 16));
    end

    // stall scenario from a fresh reset
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;            // c0 IDLE
    tick();                          // c1 fetch 0x00
    @(negedge clk); chk("st_a0", rom_addr, 32'h00);
    tick(); stall = 1'b1;            // c2 fetch 0x10, head 0x00 held
    @(negedge clk);
    chk("st_a1", rom_addr, 32'h10);
    chk("st_h0", if_pc, 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("st_ce_full", 32'(rom_ce), 32'd0);
      chk("st_hold", if_pc, 32'h00);
    end
    tick(); stall = 1'b0;            // c6 pop 0x00, fetch 0x20
    @(negedge clk);
    chk("st_r_pc0", if_pc, 32'h00);
    chk("st_r_a", rom_addr, 32'h20);
    tick(); @(negedge clk);          // c7
    chk("st_r_pc1", if_pc, 32'h10);
    chk("st_r_a1", rom_addr, 32'h30);

    // flush while full
    tick(); stall = 1'b1;            // c8 full, stalled
    @(negedge clk);
    chk("fl_pre_pc", if_pc, 32'h20);
    chk("fl_pre_ce", 32'(rom_ce), 32'd0);
    tick(); flush = 1'b1; flush_pc = 32'h100;   // c9
    @(negedge clk); chk("fl_ce", 32'(rom_ce), 32'd0);
    tick(); flush = 1'b0; stall = 1'b0;         // c10
    @(negedge clk);
    chk("fl_valid", 32'(if_valid), 32'd0);
    chk("fl_addr", rom_addr, 32'h100);
    tick(); @(negedge clk);                     // c11
    chk("fl_ifpc", if_pc, 32'h100);
    chk("fl_vld", 32'(if_valid), 32'd1);

    // debug request held three cycles
    tick(); dbg_req = 1'b1; dbg_addr = 32'h30;  // c12
    @(negedge clk); chk("dbg_c12_addr", rom_addr, 32'h120);
    tick(); @(negedge clk);                     // c13 DEBUG
    chk("dbg_addr1", rom_addr, 32'h30);
    chk("dbg_ce1", 32'(rom_ce), 32'd1);
    tick(); @(negedge clk);                     // c14 FETCH
    chk("dbg_ack1", 32'(dbg_ack), 32'd1);
    chk("dbg_data1", dbg_data, 32'hC0DE_0030);
    chk("dbg_pc_kept", rom_addr, 32'h130);
    tick(); dbg_req = 1'b0;                     // c15 DEBUG
    @(negedge clk);
    chk("dbg_addr2", rom_addr, 32'h30);
    chk("dbg_ack_gap", 32'(dbg_ack), 32'd0);
    tick(); @(negedge clk);                     // c16
    chk("dbg_ack2", 32'(dbg_ack), 32'd1);
    chk("dbg_pc_kept2", rom_addr, 32'h140);

    // flush and debug on the same cycle
    tick(); flush = 1'b1; flush_pc = 32'h200; dbg_req = 1'b1; dbg_addr = 32'h40;  // c17
    @(negedge clk);
    chk("fd_ce", 32'(rom_ce), 32'd0);
    chk("fd_ack", 32'(dbg_ack), 32'd0);
    tick(); flush = 1'b0;                       // c18 FETCH, grant
    @(negedge clk);
    chk("fd_addr", rom_addr, 32'h200);
    chk("fd_valid", 32'(if_valid), 32'd0);
    tick(); dbg_req = 1'b0;                     // c19 DEBUG
    @(negedge clk);
    chk("fd_dbg_addr", rom_addr, 32'h40);
    chk("fd_ifpc", if_pc, 32'h200);
    tick(); @(negedge clk);                     // c20
    chk("fd_ack", 32'(dbg_ack), 32'd1);
    chk("fd_data", dbg_data, 32'hC0DE_0040);
    chk("fd_next", rom_addr, 32'h210);

    // reset in the middle of a DEBUG cycle
    tick(); dbg_req = 1'b1; dbg_addr = 32'h50;  // c21
    tick(); dbg_req = 1'b0;                     // c22 DEBUG
    chk("rd_addr", rom_addr, 32'h50);
    #1 rst_n = 1'b0;
    #1;
    chk("rd_ce", 32'(rom_ce), 32'd0);
    chk("rd_addr0", rom_addr, 32'h0);
    chk("rd_valid", 32'(if_valid), 32'd0);
    chk("rd_ifpc", if_pc, 32'h0);
    chk("rd_ack", 32'(dbg_ack), 32'd0);
    chk("rd_data", dbg_data, 32'h0);
    tick(); rst_n = 1'b1;                       // IDLE
    @(negedge clk);
    chk("rd_idle_ce", 32'(rom_ce), 32'd0);
    chk("rd_noack0", 32'(dbg_ack), 32'd0);
    tick(); @(negedge clk);
    chk("rd_noack1", 32'(dbg_ack), 32'd0);
    chk("rd_refetch", rom_addr, 32'h0);

    // pc wraps modulo 2^32
    tick(); flush = 1'b1; flush_pc = 32'hFFFF_FFF0;
    tick(); flush = 1'b0;
    @(negedge clk); chk("wrap_a", rom_addr, 32'hFFFF_FFF0);
    tick(); @(negedge clk);
    chk("wrap_b", rom_addr, 32'h0);
    chk("wrap_ifpc", if_pc, 32'hFFFF_FFF0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, prefetch entries (power of two, 2..4).
REQ-003 SHALL have port clk  input  1  sole clock; all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rom_ce  output  1  instruction ROM chip enable.
REQ-006 SHALL have port rom_addr  output  `InstAddrBus  ROM byte address.
REQ-007 SHALL have port rom_inst  input  `InstBus  ROM data (combinational, same cycle as rom_addr).
REQ-008 SHALL have ports stall  input  1  decode cannot accept; flush  input  1  redirect; flush_pc  input  `InstAddrBus  redirect target.
REQ-009 SHALL have ports if_valid  output  1; if_inst  output  `InstBus; if_pc  output  `InstAddrBus  (fetched instruction to decode).
REQ-010 SHALL have ports dbg_req  input  1; dbg_addr  input  `InstAddrBus; dbg_ack  output  1; dbg_data  output  `InstBus  (debug read port).

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, DEBUG; reset enters IDLE; IDLE -> FETCH on the first clock after rst_n deasserts.
REQ-012 SHALL, in FETCH with FIFO not full (or full and popping) and no flush, drive rom_ce=1, rom_addr=pc, push {pc, rom_inst} at the clock edge, and advance pc by `InstStride (16 bytes).
REQ-013 SHALL drive rom_ce=0 and rom_addr=0 whenever neither a fetch nor a debug access occurs that cycle.
REQ-014 SHALL present the FIFO head registered on if_inst/if_pc with if_valid=1 when non-empty; fetch-to-if_valid latency is 1 cycle.
REQ-015 SHALL pop the head on a cycle with if_valid=1 and stall=0; stall=1 holds if_inst/if_pc stable.
REQ-016 SHALL allow simultaneous push and pop when full; SHALL not push when full and not popping (pc unchanged).
REQ-017 SHALL, on flush=1, empty the FIFO, set pc to flush_pc, suppress that cycle's push, and show if_valid=0 the following cycle; flush overrides stall.
REQ-018 SHALL grant dbg_req from FETCH, when flush=0, by entering DEBUG for exactly one cycle: rom_ce=1, rom_addr=dbg_addr, no core push, pc unchanged.
REQ-019 SHALL, at the end of the DEBUG cycle, register rom_inst into dbg_data and pulse dbg_ack=1 for one cycle; dbg_data holds until the next grant.
REQ-020 SHALL, after any DEBUG cycle, spend at least one cycle in FETCH before the next debug grant (anti-starvation).
REQ-021 SHALL give flush priority over dbg_req on the same cycle; the debug request remains pending.
REQ-022 SHALL wrap pc modulo 2^32 with no error indication.

Reset
REQ-023 SHALL, while rst_n=0, force: state=IDLE, pc=RESET_PC, FIFO empty, rom_ce=0, rom_addr=0, if_valid=0, if_inst=`ZeroDoubleWord, if_pc=0, dbg_ack=0, dbg_data=0.
REQ-024 SHALL abort any in-flight fetch or debug access on reset assertion; no dbg_ack issues for it.

Structure
REQ-025 SHALL take `InstAddrBus, `InstBus, `ZeroDoubleWord, `ChipEnable/`ChipDisable from defines.v and add `InstStride (16) and the FSM state encodings there.
REQ-026 SHALL implement the prefetch queue as a sub-module fetch_fifo (push, pop, clear, full, empty, head) instantiated once.

Verification
REQ-027 SHALL verify reset release, RESET_PC=0, stall=0 -> rom_addr 0x00,0x10,0x20 on consecutive cycles; if_pc 0x00,0x10,0x20 one cycle later.
REQ-028 SHALL verify stall=1 for 4 cycles after two fetches -> rom_ce=0 after FIFO fills, if_pc held at 0x00, resumes with 0x10 with no loss or duplication.
REQ-029 SHALL verify flush=1, flush_pc=0x100 while full -> next cycle if_valid=0, rom_addr=0x100; following cycle if_pc=0x100.
REQ-030 SHALL verify dbg_req=1, dbg_addr=0x30 held for 3 cycles -> grants not back-to-back, dbg_ack pulse with dbg_data = ROM word at 0x30, core pc unchanged across grants.
REQ-031 SHALL verify flush and dbg_req asserted same cycle -> flush taken, debug granted the following FETCH cycle.
REQ-032 SHALL verify rst_n asserted mid DEBUG cycle -> all outputs at reset values immediately, no dbg_ack after release.
